ptw_arbiter: RTL and testbench

//  Shares the single page-table walker between NUM_REQ TLB-miss requesters (default I-TLB=0, D-TLB=1).

---
 rtl/ptw_arbiter_pkg.sv | 19 +
 rtl/ptw_arbiter_if.sv | 41 ++++
 rtl/ptw_arbiter_rr_arbiter.sv | 30 +++
 rtl/ptw_arbiter.sv | 139 +++++++++++++
 tb/tb_ptw_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ptw_arbiter_pkg.sv
// Shared MMU types and constants for the page-table-walker arbiter.
// Holds the FSM state encoding, the watchdog fault code and the default address widths.
package ptw_arbiter_pkg;

  localparam int MMU_VADDR_WIDTH         = 39;
  localparam int MMU_PADDR_WIDTH         = 56;
  localparam int PTW_ARB_TIMEOUT_DEFAULT = 1024;

  localparam logic [3:0] PTW_FAULT_TIMEOUT = 4'hF;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP,
    ARB_DRAIN
  } ptw_arb_state_e;

endpackage

// File: rtl/ptw_arbiter_if.sv
// TLB-side request/response and walker-side handshake bundle for the PTW arbiter.
// slave = arbiter view; master = the surrounding TLBs plus walker.
interface ptw_arbiter_if
  import ptw_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int VADDR_WIDTH = MMU_VADDR_WIDTH,
  parameter int PADDR_WIDTH = MMU_PADDR_WIDTH
);

  logic [NUM_REQ-1:0]     req_valid_i;
  logic [VADDR_WIDTH-1:0] req_vaddr_i [NUM_REQ];
  logic [NUM_REQ-1:0]     req_ready_o;
  logic [NUM_REQ-1:0]     resp_valid_o;
  logic [PADDR_WIDTH-1:0] resp_paddr_o;
  logic                   resp_fault_o;
  logic [3:0]             resp_fault_type_o;

  logic                   ptw_req_valid_o;
  logic                   ptw_req_ready_i;
  logic [VADDR_WIDTH-1:0] ptw_vaddr_o;
  logic                   ptw_done_i;
  logic [PADDR_WIDTH-1:0] ptw_paddr_i;
  logic                   ptw_fault_i;
  logic [3:0]             ptw_fault_type_i;

  modport slave (
    input  req_valid_i, req_vaddr_i, ptw_req_ready_i, ptw_done_i,
           ptw_paddr_i, ptw_fault_i, ptw_fault_type_i,
    output req_ready_o, resp_valid_o, resp_paddr_o, resp_fault_o,
           resp_fault_type_o, ptw_req_valid_o, ptw_vaddr_o
  );

  modport master (
    output req_valid_i, req_vaddr_i, ptw_req_ready_i, ptw_done_i,
           ptw_paddr_i, ptw_fault_i, ptw_fault_type_i,
    input  req_ready_o, resp_valid_o, resp_paddr_o, resp_fault_o,
           resp_fault_type_o, ptw_req_valid_o, ptw_vaddr_o
  );

endinterface

// File: rtl/ptw_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
// Returns a one-hot grant, its index, and whether anything was requesting.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between NUM_REQ TLB miss requesters, one walk at a time.
// Round-robin grant, watchdog on the walk, and sfence flush that suppresses the in-flight response.
module ptw_arbiter
  import ptw_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int VADDR_WIDTH    = MMU_VADDR_WIDTH,
  parameter int PADDR_WIDTH    = MMU_PADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = PTW_ARB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  output logic          busy_o,
  ptw_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  ptw_arb_state_e         state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       owner;
  logic                   flush_pend;
  logic                   drain;
  logic [WD_W-1:0]        wd_cnt;

  logic [VADDR_WIDTH-1:0] vaddr_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic                   fault_q;
  logic [3:0]             fault_type_q;

  logic [NUM_REQ-1:0]     win_grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_any;
  logic                   grant_en;
  logic                   resp_active;
  logic                   wd_expire;
  logic [NUM_REQ-1:0]     resp_valid;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (bus.req_valid_i),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Grant is gated by rst_n so no requester sees an accept that the FSM never latched.
  assign grant_en    = rst_n && (state == ARB_IDLE) && !flush_i && win_any;
  assign resp_active = (state == ARB_RESP) && !(flush_pend || flush_i);
  assign wd_expire   = (state == ARB_WAIT) && !bus.ptw_done_i && (wd_cnt == WD_LAST);

  always_comb begin
    resp_valid = '0;
    if (resp_active) resp_valid[owner] = 1'b1;
  end

  assign bus.req_ready_o       = grant_en ? win_grant : '0;
  assign bus.resp_valid_o      = resp_valid;
  assign bus.resp_paddr_o      = resp_active ? paddr_q      : '0;
  assign bus.resp_fault_o      = resp_active ? fault_q      : 1'b0;
  assign bus.resp_fault_type_o = resp_active ? fault_type_q : 4'h0;
  assign bus.ptw_req_valid_o   = (state == ARB_ISSUE);
  assign bus.ptw_vaddr_o       = (state == ARB_ISSUE) ? vaddr_q : '0;
  assign busy_o                = (state != ARB_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      flush_pend <= 1'b0;
      drain      <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      if (flush_i && (state != ARB_IDLE)) flush_pend <= 1'b1;
      unique case (state)
        ARB_IDLE: begin
          if (grant_en) begin
            owner <= win_idx;
            state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.ptw_req_ready_i) begin
            wd_cnt <= '0;
            state  <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.ptw_done_i) begin
            state <= ARB_RESP;
          end else if (wd_expire) begin
            drain <= 1'b1;
            state <= ARB_RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ARB_RESP: begin
          rr_ptr <= (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
          if (drain) begin
            state <= ARB_DRAIN;
          end else begin
            flush_pend <= 1'b0;
            state      <= ARB_IDLE;
          end
        end
        ARB_DRAIN: begin
          // The walker still owes a completion for the timed-out walk; swallow it.
          if (bus.ptw_done_i) begin
            drain      <= 1'b0;
            flush_pend <= 1'b0;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Walk payload registers carry no reset; every output use is qualified by state.
  always_ff @(posedge clk) begin
    if (grant_en) vaddr_q <= bus.req_vaddr_i[win_idx];
    if ((state == ARB_WAIT) && bus.ptw_done_i) begin
      paddr_q      <= bus.ptw_paddr_i;
      fault_q      <= bus.ptw_fault_i;
      fault_type_q <= bus.ptw_fault_type_i;
    end else if (wd_expire) begin
      paddr_q      <= '0;
      fault_q      <= 1'b1;
      fault_type_q <= PTW_FAULT_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: two requesters, short watchdog, hand-computed expectations.
module tb_ptw_arbiter;

  localparam int NR = 2;
  localparam int VW = 39;
  localparam int PW = 56;

  logic clk;
  logic rst_n;
  logic flush_i;
  logic busy_o;
  int   checks;
  int   errors;

  ptw_arbiter_if #(.NUM_REQ(NR), .VADDR_WIDTH(VW), .PADDR_WIDTH(PW)) bus ();

  ptw_arbiter #(
    .NUM_REQ(NR), .VADDR_WIDTH(VW), .PADDR_WIDTH(PW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    flush_i = 1'b0;
    bus.req_valid_i      = 2'b11;
    bus.req_vaddr_i[0]   = 39'h1000;
    bus.req_vaddr_i[1]   = 39'h2000;
    bus.ptw_req_ready_i  = 1'b1;
    bus.ptw_done_i       = 1'b0;
    bus.ptw_paddr_i      = '0;
    bus.ptw_fault_i      = 1'b0;
    bus.ptw_fault_type_i = 4'h0;

    // Reset with both requests already pending
    repeat (2) step();
    #1;
    check("rst_req_ready", 64'(bus.req_ready_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_ptw_valid", 64'(bus.ptw_req_valid_o), 64'h0);
    check("rst_resp_valid", 64'(bus.resp_valid_o), 64'h0);
    check("rst_ptw_vaddr", 64'(bus.ptw_vaddr_o), 64'h0);

    // Test 1: req0 first, then req1
    rst_n = 1'b1;
    #1;
    check("t1_grant0", 64'(bus.req_ready_o), 64'h1);
    step(); bus.req_valid_i = 2'b10; #1;
    check("t1_issue_valid", 64'(bus.ptw_req_valid_o), 64'h1);
    check("t1_issue_vaddr", 64'(bus.ptw_vaddr_o), 64'h1000);
    check("t1_busy", 64'(busy_o), 64'h1);
    check("t1_no_grant_busy", 64'(bus.req_ready_o), 64'h0);
    step(); #1;
    check("t1_wait_novalid", 64'(bus.ptw_req_valid_o), 64'h0);
    step(); step();
    bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'h8000_1234;
    #1;
    check("t1_wait_noresp", 64'(bus.resp_valid_o), 64'h0);
    step(); bus.ptw_done_i = 1'b0; bus.ptw_paddr_i = '0; #1;
    check("t1_resp0_valid", 64'(bus.resp_valid_o), 64'h1);
    check("t1_resp0_paddr", 64'(bus.resp_paddr_o), 64'h8000_1234);
    check("t1_resp0_fault", 64'(bus.resp_fault_o), 64'h0);
    check("t1_resp_no_grant", 64'(bus.req_ready_o), 64'h0);
    step(); #1;
    check("t1_pulse_end", 64'(bus.resp_valid_o), 64'h0);
    check("t1_paddr_zero", 64'(bus.resp_paddr_o), 64'h0);
    check("t1_grant1", 64'(bus.req_ready_o), 64'h2);
    step(); bus.req_valid_i = 2'b00; #1;
    check("t1_issue1_vaddr", 64'(bus.ptw_vaddr_o), 64'h2000);
    step(); bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'h8000_5678;
    step(); bus.ptw_done_i = 1'b0; #1;
    check("t1_resp1_valid", 64'(bus.resp_valid_o), 64'h2);
    check("t1_resp1_paddr", 64'(bus.resp_paddr_o), 64'h8000_5678);
    step();

    // Test 2: req1 alone, walker stalls 5 cycles
    bus.ptw_req_ready_i = 1'b0;
    bus.req_valid_i = 2'b10; bus.req_vaddr_i[1] = 39'h3000; #1;
    check("t2_grant1", 64'(bus.req_ready_o), 64'h2);
    step(); bus.req_valid_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_hold_valid", 64'(bus.ptw_req_valid_o), 64'h1);
      check("t2_hold_vaddr", 64'(bus.ptw_vaddr_o), 64'h3000);
      step();
    end
    bus.ptw_req_ready_i = 1'b1; #1;
    check("t2_accept_valid", 64'(bus.ptw_req_valid_o), 64'h1);
    check("t2_accept_vaddr", 64'(bus.ptw_vaddr_o), 64'h3000);
    step(); #1;
    check("t2_wait_novalid", 64'(bus.ptw_req_valid_o), 64'h0);
    bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'hAB_C000;
    step(); bus.ptw_done_i = 1'b0; #1;
    check("t2_resp_valid", 64'(bus.resp_valid_o), 64'h2);
    check("t2_resp_paddr", 64'(bus.resp_paddr_o), 64'hAB_C000);
    step();

    // Test 3: walker fault 4'hC
    bus.req_valid_i = 2'b01; bus.req_vaddr_i[0] = 39'h4000; #1;
    check("t3_grant0", 64'(bus.req_ready_o), 64'h1);
    step(); bus.req_valid_i = 2'b00;
    step();
    bus.ptw_done_i = 1'b1; bus.ptw_fault_i = 1'b1; bus.ptw_fault_type_i = 4'hC; bus.ptw_paddr_i = '0;
    step();
    bus.ptw_done_i = 1'b0; bus.ptw_fault_i = 1'b0; bus.ptw_fault_type_i = 4'h0; #1;
    check("t3_resp_valid", 64'(bus.resp_valid_o), 64'h1);
    check("t3_fault", 64'(bus.resp_fault_o), 64'h1);
    check("t3_fault_type", 64'(bus.resp_fault_type_o), 64'hC);
    check("t3_paddr", 64'(bus.resp_paddr_o), 64'h0);
    step(); #1;
    check("t3_pulse_end", 64'(bus.resp_valid_o), 64'h0);
    check("t3_fault_cleared", 64'(bus.resp_fault_o), 64'h0);
    check("t3_type_cleared", 64'(bus.resp_fault_type_o), 64'h0);

    // Test 4: watchdog at cycle 8 of WAIT, late done swallowed in drain
    bus.req_valid_i = 2'b01; bus.req_vaddr_i[0] = 39'h5000; #1;
    check("t4_grant0_wrap", 64'(bus.req_ready_o), 64'h1);
    step(); bus.req_valid_i = 2'b00;
    step();
    for (int i = 0; i < 7; i++) begin
      #1;
      check("t4_wait_noresp", 64'(bus.resp_valid_o), 64'h0);
      step();
    end
    #1;
    check("t4_cycle8_noresp", 64'(bus.resp_valid_o), 64'h0);
    check("t4_cycle8_busy", 64'(busy_o), 64'h1);
    step(); #1;
    check("t4_to_valid", 64'(bus.resp_valid_o), 64'h1);
    check("t4_to_fault", 64'(bus.resp_fault_o), 64'h1);
    check("t4_to_type", 64'(bus.resp_fault_type_o), 64'hF);
    check("t4_to_paddr", 64'(bus.resp_paddr_o), 64'h0);
    step(); bus.req_valid_i = 2'b10; bus.req_vaddr_i[1] = 39'h6600; #1;
    check("t4_drain_busy", 64'(busy_o), 64'h1);
    check("t4_drain_nogrant", 64'(bus.req_ready_o), 64'h0);
    step(); step();
    bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'h9999; #1;
    check("t4_late_swallowed", 64'(bus.resp_valid_o), 64'h0);
    step(); bus.ptw_done_i = 1'b0; bus.ptw_paddr_i = '0; #1;
    check("t4_idle_noresp", 64'(bus.resp_valid_o), 64'h0);
    check("t4_idle_notbusy", 64'(busy_o), 64'h0);
    check("t4_grant1", 64'(bus.req_ready_o), 64'h2);
    step(); bus.req_valid_i = 2'b00; #1;
    check("t4_issue_vaddr", 64'(bus.ptw_vaddr_o), 64'h6600);
    step(); bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'h7000;
    step(); bus.ptw_done_i = 1'b0; #1;
    check("t4_after_valid", 64'(bus.resp_valid_o), 64'h2);
    check("t4_after_paddr", 64'(bus.resp_paddr_o), 64'h7000);
    check("t4_after_fault", 64'(bus.resp_fault_o), 64'h0);
    step();

    // Test 5: flush blocks grant in IDLE, suppresses response in WAIT
    bus.req_valid_i = 2'b01; flush_i = 1'b1; #1;
    check("t5_flush_blocks", 64'(bus.req_ready_o), 64'h0);
    flush_i = 1'b0; #1;
    check("t5_grant0", 64'(bus.req_ready_o), 64'h1);
    step(); bus.req_valid_i = 2'b00;
    step(); flush_i = 1'b1;
    step(); flush_i = 1'b0; bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'h1111;
    step(); bus.ptw_done_i = 1'b0; bus.ptw_paddr_i = '0; #1;
    check("t5_suppressed", 64'(bus.resp_valid_o), 64'h0);
    check("t5_paddr_zero", 64'(bus.resp_paddr_o), 64'h0);
    check("t5_resp_busy", 64'(busy_o), 64'h1);
    bus.req_valid_i = 2'b11; #1;
    check("t5_resp_nogrant", 64'(bus.req_ready_o), 64'h0);
    step(); #1;
    check("t5_rr_advanced", 64'(bus.req_ready_o), 64'h2);
    step(); bus.req_valid_i = 2'b01;
    step(); bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'h2222;
    step(); bus.ptw_done_i = 1'b0; #1;
    check("t5_next_valid", 64'(bus.resp_valid_o), 64'h2);
    check("t5_next_paddr", 64'(bus.resp_paddr_o), 64'h2222);
    step(); #1;
    check("t5_grant0_again", 64'(bus.req_ready_o), 64'h1);
    step(); bus.req_valid_i = 2'b00;
    step(); bus.ptw_done_i = 1'b1; bus.ptw_paddr_i = 56'h3333;
    step(); bus.ptw_done_i = 1'b0; #1;
    check("t5_req0_valid", 64'(bus.resp_valid_o), 64'h1);
    step();

    // Test 6: reset in WAIT, pointer returns to req0
    bus.req_valid_i = 2'b10; bus.req_vaddr_i[1] = 39'h6000; #1;
    check("t6_grant1", 64'(bus.req_ready_o), 64'h2);
    step(); bus.req_valid_i = 2'b00;
    step(); step();
    rst_n = 1'b0; bus.req_valid_i = 2'b11; bus.req_vaddr_i[0] = 39'h7700; #1;
    check("t6_rst_busy", 64'(busy_o), 64'h0);
    check("t6_rst_ptw_valid", 64'(bus.ptw_req_valid_o), 64'h0);
    check("t6_rst_resp_valid", 64'(bus.resp_valid_o), 64'h0);
    check("t6_rst_req_ready", 64'(bus.req_ready_o), 64'h0);
    check("t6_rst_ptw_vaddr", 64'(bus.ptw_vaddr_o), 64'h0);
    step(); rst_n = 1'b1; #1;
    check("t6_grant0", 64'(bus.req_ready_o), 64'h1);
    step(); bus.req_valid_i = 2'b10; #1;
    check("t6_issue_vaddr", 64'(bus.ptw_vaddr_o), 64'h7700);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
